// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, key type and key-schedule state enum
package aes_pkg;

   localparam int NUM_ROUNDS = 10;

   typedef logic [127:0] aes_key_t;

   typedef enum logic [1:0] {
      KS_IDLE   = 2'd0,
      KS_EXPAND = 2'd1,
      KS_READY  = 2'd2
   } ks_state_e;

   // Indexed directly by the 4-bit round counter; entries 0 and 11..15 are never used.
   localparam logic [7:0] RCON [16] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box
// Multiplicative inverse in GF(2^8) followed by the FIPS-197 affine transform.
module aes_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 == x^-1 for nonzero x and maps 0 to 0, as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      r = x;
      for (int i = 0; i < 6; i++) begin
         r = gf_mul(gf_mul(r, r), x);
      end
      return gf_mul(r, r);
   endfunction

   logic [7:0] inv;

   assign inv      = gf_inv(in_byte);
   assign out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - AES-128 key expansion, one round per cycle, with round-key store
// Round key 0 is exported directly; all keys are readable through a zero-latency address port.
module aes_key_schedule
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         key_load,
   input  logic [127:0] key_in,
   input  logic [3:0]   read_addr,
   output logic [127:0] round_key_input,
   output logic [127:0] round_key_0,
   output logic         key_ready,
   output logic         key_busy
);

   ks_state_e state_q, state_d;
   logic [3:0] rnd_q, rnd_d;
   aes_key_t   key_mem_q [NUM_ROUNDS+1];
   aes_key_t   key_mem_d [NUM_ROUNDS+1];

   aes_key_t    prev_key;
   aes_key_t    next_key;
   logic [31:0] rot_word;
   logic [31:0] sub_word;
   logic [31:0] t_word;
   logic [31:0] n0, n1, n2, n3;

   always_comb begin
      prev_key = '0;
      for (int i = 1; i <= NUM_ROUNDS; i++) begin
         if (rnd_q == 4'(i)) prev_key = key_mem_q[i-1];
      end
   end

   assign rot_word = {prev_key[23:0], prev_key[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_subword
      aes_sbox u_sbox (
         .in_byte  (rot_word[8*b +: 8]),
         .out_byte (sub_word[8*b +: 8])
      );
   end

   assign t_word   = sub_word ^ {RCON[rnd_q], 24'h0};
   assign n0       = prev_key[127:96] ^ t_word;
   assign n1       = prev_key[95:64]  ^ n0;
   assign n2       = prev_key[63:32]  ^ n1;
   assign n3       = prev_key[31:0]   ^ n2;
   assign next_key = {n0, n1, n2, n3};

   always_comb begin
      state_d   = state_q;
      rnd_d     = rnd_q;
      key_mem_d = key_mem_q;
      if (key_load) begin
         key_mem_d[0] = key_in;
         rnd_d        = 4'd1;
         state_d      = KS_EXPAND;
      end else if (state_q == KS_EXPAND) begin
         for (int i = 1; i <= NUM_ROUNDS; i++) begin
            if (rnd_q == 4'(i)) key_mem_d[i] = next_key;
         end
         if (rnd_q == 4'(NUM_ROUNDS)) begin
            state_d = KS_READY;
         end else begin
            rnd_d = rnd_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= KS_IDLE;
         rnd_q     <= 4'd0;
         key_mem_q <= '{default: '0};
      end else begin
         state_q   <= state_d;
         rnd_q     <= rnd_d;
         key_mem_q <= key_mem_d;
      end
   end

   always_comb begin
      round_key_input = '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
         if (read_addr == 4'(i)) round_key_input = key_mem_q[i];
      end
   end

   assign round_key_0 = key_mem_q[0];
   assign key_busy    = (state_q == KS_EXPAND);
   assign key_ready   = (state_q == KS_READY);

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

- Expands one AES-128 cipher key into the 11 round keys, one round per cycle, and stores them.
- Sits directly upstream of the AES encrypt/decrypt datapath and serves it the round keys:
  - round key 0 is always presented on its own port;
  - rounds 1..10 are read through a 4-bit address port that the active engine drives.
- Signals `key_ready` once the whole schedule is valid.

## Interface
- Parameters: none. Fixed AES-128: 10 rounds, 128-bit key.
- `clk` in 1 — system clock; all state updates on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `key_load` in 1 — single-cycle pulse; `key_in` is sampled on the same edge.
- `key_in` in 128 — cipher key. Bits [127:120] are byte 0 (FIPS-197 byte order).
- `read_addr` in 4 — round-key index 0..10, driven by the encrypt/decrypt engine.
- `round_key_input` out 128 — combinational read of the stored key at `read_addr`.
- `round_key_0` out 128 — stored key 0 (the cipher key), registered.
- `key_ready` out 1 — all 11 keys valid.
- `key_busy` out 1 — expansion in progress.

## Operation
- States:
  - IDLE: no key loaded.
  - EXPAND: expansion in progress.
  - READY: all keys valid.
- Key storage: array `key_mem[0..10]` of 128-bit entries. Round counter `rnd`, 4 bits.
- `key_load` in any state (IDLE, EXPAND, READY):
  - `key_mem[0] <= key_in`;
  - `rnd <= 1`;
  - state → EXPAND.
  - A load during EXPAND or READY restarts expansion; the old schedule is abandoned.
- EXPAND, each cycle without `key_load`:
  - Compute and write `key_mem[rnd]` from `key_mem[rnd-1]`:
    - words w0..w3 of the previous key: w0 = [127:96], w3 = [31:0];
    - t = SubWord(RotWord(w3)) ^ {rcon[rnd], 24'h0};
    - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - If `rnd == 10`: state → READY. Otherwise `rnd <= rnd + 1`.
- rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- READY: hold the stored keys until the next `key_load` or `rst`.
- Read port:
  - `round_key_input = key_mem[read_addr]` for `read_addr` 0..10.
  - Returns 128'h0 for `read_addr` 11..15.
- Outputs by state:
  - `key_busy` = (state == EXPAND);
  - `key_ready` = (state == READY).
- Reads while not READY return stored contents: stale from the previous key or partially updated. Downstream must gate on `key_ready`.
- Reset:
  - state IDLE, `rnd` 0, every `key_mem` entry 0;
  - `round_key_0` = 0, `round_key_input` = 0 for any address;
  - `key_ready` = 0, `key_busy` = 0.
- Reset asserted mid-expansion has priority over `key_load` in the same cycle: the block ends in IDLE with all storage cleared.

## Timing
- `key_load` sampled at edge T0:
  - `round_key_0` shows the new key after T0;
  - `key_busy` = 1 after T0;
  - round key k is written at edge Tk, for k = 1..10.
- After edge T10: `key_ready` = 1 and `key_busy` = 0. Latency from load to ready is 10 cycles.
- Read port latency: `round_key_input` follows `read_addr` combinationally with zero cycles. The engine can present an address and consume the key in the same cycle.
- `key_load` re-asserted while READY: `key_ready` falls after that edge and rises again 10 edges later.
- `key_load` held high for multiple cycles restarts the schedule every cycle. `key_ready` is not asserted until 10 cycles after the last high sample.
- Critical path: one SubWord (4 S-box lookups) plus the XOR chain. No pipelining.

## Structure
- Shared package `aes_pkg` holds:
  - `NUM_ROUNDS = 10`;
  - the rcon constant array;
  - the key-schedule state enum;
  - the 128-bit key typedef.
- Sub-module `aes_sbox`: combinational 8-bit forward S-box, instanced 4 times for SubWord. The cipher datapath reuses the same module.

## Test plan
- Reset then idle:
  - `round_key_0` = 0, `round_key_input` = 0 at `read_addr` = 0, 5 and 15;
  - `key_ready` = 0, `key_busy` = 0.
- FIPS-197 A.1 vector, load key 2b7e151628aed2a6abf7158809cf4f3c:
  - `key_ready` rises exactly 10 cycles after the load edge;
  - addr 1 = a0fafe1788542cb123a339392a6c7605;
  - addr 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - addr 0 equals the key and equals `round_key_0`.
- All-zero key:
  - addr 1 = 62636363626363636263636362636363;
  - addr 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Restart mid-expansion:
  - load the zero key, then load the A.1 key 4 cycles later;
  - `key_ready` stays 0 until 10 cycles after the second load;
  - final addr 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Reset during EXPAND, with `key_load` asserted in the same cycle:
  - next cycle: IDLE, `key_busy` = 0, all reads 0.
- Out-of-range reads and read sweep after READY:
  - addr 11..15 = 0;
  - sweeping addr 10 down to 0 returns each key in the same cycle the address is presented.
